// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle TSC controller: opcodes, function codes,
// ALU operations, datapath select values, FSM states and instruction classes.
package multicycle_control_pkg;

  localparam logic [3:0] OPC_BNE   = 4'd0;
  localparam logic [3:0] OPC_BEQ   = 4'd1;
  localparam logic [3:0] OPC_BGZ   = 4'd2;
  localparam logic [3:0] OPC_BLZ   = 4'd3;
  localparam logic [3:0] OPC_ADI   = 4'd4;
  localparam logic [3:0] OPC_ORI   = 4'd5;
  localparam logic [3:0] OPC_LHI   = 4'd6;
  localparam logic [3:0] OPC_LWD   = 4'd7;
  localparam logic [3:0] OPC_SWD   = 4'd8;
  localparam logic [3:0] OPC_JMP   = 4'd9;
  localparam logic [3:0] OPC_JAL   = 4'd10;
  localparam logic [3:0] OPC_RTYPE = 4'd15;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;
  localparam logic [5:0] FUNC_JPR = 6'd25;
  localparam logic [5:0] FUNC_JRL = 6'd26;
  localparam logic [5:0] FUNC_WWD = 6'd28;
  localparam logic [5:0] FUNC_HLT = 6'd29;

  // R-type ALU ops share the function-code value, so func_code[3:0] feeds alu_op directly
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_TCP = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_NEQ = 4'd8;
  localparam logic [3:0] ALU_EQ  = 4'd9;
  localparam logic [3:0] ALU_GTZ = 4'd10;
  localparam logic [3:0] ALU_LTZ = 4'd11;

  localparam logic       ALUSRCA_PC  = 1'b0;
  localparam logic       ALUSRCA_REG = 1'b1;

  localparam logic [1:0] ALUSRCB_REG  = 2'd0;
  localparam logic [1:0] ALUSRCB_ONE  = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM  = 2'd2;
  localparam logic [1:0] ALUSRCB_ZERO = 2'd3;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_REG    = 2'd2;
  localparam logic [1:0] PCSRC_BRANCH = 2'd3;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_TWO = 2'd2;

  localparam logic [1:0] REGWRITESRC_REG = 2'd0;
  localparam logic [1:0] REGWRITESRC_MEM = 2'd1;
  localparam logic [1:0] REGWRITESRC_PC  = 2'd2;
  localparam logic [1:0] REGWRITESRC_IMM = 2'd3;

  typedef enum logic [2:0] {
    STATE_IF   = 3'd0,
    STATE_ID   = 3'd1,
    STATE_EX   = 3'd2,
    STATE_MEM  = 3'd3,
    STATE_WB   = 3'd4,
    STATE_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_RALU, CLS_IALU, CLS_LHI, CLS_LWD, CLS_SWD, CLS_BRANCH,
    CLS_JMP, CLS_JAL, CLS_JPR, CLS_JRL, CLS_WWD, CLS_HLT
  } inst_class_e;

  // Instructions whose whole effect happens in ID and which retire there
  function automatic logic finishes_in_id(inst_class_e c);
    return (c == CLS_JMP) || (c == CLS_JAL) || (c == CLS_LHI) || (c == CLS_JPR) ||
           (c == CLS_JRL) || (c == CLS_WWD) || (c == CLS_NOP);
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational instruction classifier: (opcode, func_code) -> instruction
// class, EX-stage ALU operation, and whether a branch compares against zero.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [5:0]  func_code,
  output inst_class_e inst_class,
  output logic [3:0]  alu_op,
  output logic        branch_zero
);

  always_comb begin
    inst_class  = CLS_NOP;
    alu_op      = ALU_ADD;
    branch_zero = 1'b0;
    case (opcode)
      OPC_BNE: begin inst_class = CLS_BRANCH; alu_op = ALU_NEQ; end
      OPC_BEQ: begin inst_class = CLS_BRANCH; alu_op = ALU_EQ;  end
      OPC_BGZ: begin inst_class = CLS_BRANCH; alu_op = ALU_GTZ; branch_zero = 1'b1; end
      OPC_BLZ: begin inst_class = CLS_BRANCH; alu_op = ALU_LTZ; branch_zero = 1'b1; end
      OPC_ADI: begin inst_class = CLS_IALU;   alu_op = ALU_ADD; end
      OPC_ORI: begin inst_class = CLS_IALU;   alu_op = ALU_ORR; end
      OPC_LHI: inst_class = CLS_LHI;
      OPC_LWD: inst_class = CLS_LWD;
      OPC_SWD: inst_class = CLS_SWD;
      OPC_JMP: inst_class = CLS_JMP;
      OPC_JAL: inst_class = CLS_JAL;
      OPC_RTYPE: begin
        case (func_code)
          FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
          FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR: begin
            inst_class = CLS_RALU;
            alu_op     = func_code[3:0];
          end
          FUNC_JPR: inst_class = CLS_JPR;
          FUNC_JRL: inst_class = CLS_JRL;
          FUNC_WWD: inst_class = CLS_WWD;
          FUNC_HLT: inst_class = CLS_HLT;
          default:  inst_class = CLS_NOP;
        endcase
      end
      default: inst_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the 16-bit multicycle TSC datapath (IF/ID/EX/MEM/WB/HALT).
// Optional memory-wait watchdog enabled by defining CTRL_MEM_TIMEOUT_EN.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WORD_SIZE = 16
`ifdef CTRL_MEM_TIMEOUT_EN
  ,
  parameter int MEM_TIMEOUT = 15
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func_code,
  input  logic                 input_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 alu_src_a,
  output logic                 alu_src_swap,
  output logic                 reg_write,
  output logic                 output_write,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           reg_write_src,
  output logic [1:0]           reg_dst,
  output logic [3:0]           alu_op,
  output logic                 i_mem_read,
  output logic                 i_mem_write,
  output logic                 d_mem_read,
  output logic                 d_mem_write,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 is_halted
);

  state_e                state_q, state_d;
  logic [WORD_SIZE-1:0]  num_inst_q, num_inst_d;
  logic                  retire;
  inst_class_e           inst_class;
  logic [3:0]            ex_alu_op;
  logic                  branch_zero;
  logic                  waiting;

  multicycle_control_decode u_decode (
    .opcode      (opcode),
    .func_code   (func_code),
    .inst_class  (inst_class),
    .alu_op      (ex_alu_op),
    .branch_zero (branch_zero)
  );

  assign waiting = ((state_q == STATE_IF) || (state_q == STATE_MEM)) && !input_ready;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);
  logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      STATE_IF:  if (input_ready) state_d = STATE_ID;
      STATE_ID: begin
        if (inst_class == CLS_HLT) begin
          retire  = 1'b1;
          state_d = STATE_HALT;
        end else if (finishes_in_id(inst_class)) begin
          retire  = 1'b1;
          state_d = STATE_IF;
        end else begin
          state_d = STATE_EX;
        end
      end
      STATE_EX: begin
        if (inst_class == CLS_BRANCH) begin
          retire  = 1'b1;
          state_d = STATE_IF;
        end else if ((inst_class == CLS_LWD) || (inst_class == CLS_SWD)) begin
          state_d = STATE_MEM;
        end else begin
          state_d = STATE_WB;
        end
      end
      STATE_MEM: begin
        if (input_ready) begin
          if (inst_class == CLS_SWD) begin
            retire  = 1'b1;
            state_d = STATE_IF;
          end else begin
            state_d = STATE_WB;
          end
        end
      end
      STATE_WB: begin
        retire  = 1'b1;
        state_d = STATE_IF;
      end
      STATE_HALT: state_d = STATE_HALT;
      default:    state_d = STATE_IF;
    endcase
`ifdef CTRL_MEM_TIMEOUT_EN
    // Counter only runs while stalled; any non-waiting cycle clears it
    wait_cnt_d = 4'd0;
    if (waiting) begin
      if (wait_cnt_q == TIMEOUT_LAST) state_d = STATE_HALT;
      else                            wait_cnt_d = wait_cnt_q + 4'd1;
    end
`endif
    num_inst_d = num_inst_q + WORD_SIZE'(retire);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= STATE_IF;
      num_inst_q <= '0;
`ifdef CTRL_MEM_TIMEOUT_EN
      wait_cnt_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      num_inst_q <= num_inst_d;
`ifdef CTRL_MEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign num_inst = num_inst_q;

  // Strobes decode the current state; held low while reset_n is asserted so a
  // reset arriving mid-wait never lets a pending memory or register write through.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = ALUSRCA_PC;
    alu_src_swap  = 1'b0;
    reg_write     = 1'b0;
    output_write  = 1'b0;
    pc_src        = PCSRC_SEQ;
    alu_src_b     = ALUSRCB_REG;
    reg_write_src = REGWRITESRC_REG;
    reg_dst       = REGDST_RT;
    alu_op        = ALU_ADD;
    i_mem_read    = 1'b0;
    i_mem_write   = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    is_halted     = 1'b0;
    if (reset_n) begin
      case (state_q)
        STATE_IF: begin
          i_mem_read = 1'b1;
          alu_src_b  = ALUSRCB_ONE;
          ir_write   = input_ready;
          pc_write   = input_ready;
        end
        STATE_ID: begin
          alu_src_b = ALUSRCB_IMM;
          case (inst_class)
            CLS_JMP: begin pc_write = 1'b1; pc_src = PCSRC_JUMP; end
            CLS_JAL: begin
              pc_write      = 1'b1;
              pc_src        = PCSRC_JUMP;
              reg_write     = 1'b1;
              reg_dst       = REGDST_TWO;
              reg_write_src = REGWRITESRC_PC;
            end
            CLS_LHI: begin reg_write = 1'b1; reg_write_src = REGWRITESRC_IMM; end
            CLS_JPR: begin pc_write = 1'b1; pc_src = PCSRC_REG; end
            CLS_JRL: begin
              pc_write      = 1'b1;
              pc_src        = PCSRC_REG;
              reg_write     = 1'b1;
              reg_dst       = REGDST_TWO;
              reg_write_src = REGWRITESRC_PC;
            end
            CLS_WWD: output_write = 1'b1;
            default: ;
          endcase
        end
        STATE_EX: begin
          alu_src_a = ALUSRCA_REG;
          alu_op    = ex_alu_op;
          case (inst_class)
            CLS_IALU, CLS_LWD, CLS_SWD: alu_src_b = ALUSRCB_IMM;
            CLS_BRANCH: begin
              alu_src_b     = branch_zero ? ALUSRCB_ZERO : ALUSRCB_REG;
              pc_write_cond = 1'b1;
              pc_src        = PCSRC_BRANCH;
            end
            default: alu_src_b = ALUSRCB_REG;
          endcase
        end
        STATE_MEM: begin
          i_or_d      = 1'b1;
          d_mem_read  = (inst_class == CLS_LWD);
          d_mem_write = (inst_class == CLS_SWD);
        end
        STATE_WB: begin
          reg_write = 1'b1;
          case (inst_class)
            CLS_RALU: reg_dst = REGDST_RD;
            CLS_LWD:  reg_write_src = REGWRITESRC_MEM;
            default:  ;
          endcase
        end
        STATE_HALT: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one vector per clock cycle, plus
// hand sequences for reset during a memory wait and the fetch-stall limit.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic        input_ready;
  logic        pc_write, pc_write_cond, i_or_d, ir_write, alu_src_a, alu_src_swap;
  logic        reg_write, output_write;
  logic [1:0]  pc_src, alu_src_b, reg_write_src, reg_dst;
  logic [3:0]  alu_op;
  logic        i_mem_read, i_mem_write, d_mem_read, d_mem_write;
  logic [15:0] num_inst;
  logic        is_halted;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef CTRL_MEM_TIMEOUT_EN
  multicycle_control #(.WORD_SIZE(16), .MEM_TIMEOUT(4)) dut (
`else
  multicycle_control #(.WORD_SIZE(16)) dut (
`endif
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
    .input_ready(input_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .ir_write(ir_write), .alu_src_a(alu_src_a),
    .alu_src_swap(alu_src_swap), .reg_write(reg_write), .output_write(output_write),
    .pc_src(pc_src), .alu_src_b(alu_src_b), .reg_write_src(reg_write_src),
    .reg_dst(reg_dst), .alu_op(alu_op), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .num_inst(num_inst), .is_halted(is_halted)
  );

  // Strobe bit positions within the observed 12-bit strobe bus
  localparam logic [11:0] NONE = 12'h000, PCW = 12'h800, PWC = 12'h400, IOD = 12'h200;
  localparam logic [11:0] IRW  = 12'h100, SA  = 12'h080, RW  = 12'h020, OW  = 12'h010;
  localparam logic [11:0] IMR  = 12'h008, DMR = 12'h002, DMW = 12'h001;

  localparam logic [1:0] PS_SEQ = 2'd0, PS_JUMP = 2'd1, PS_REG = 2'd2, PS_BR = 2'd3;
  localparam logic [1:0] BS_REG = 2'd0, BS_ONE = 2'd1, BS_IMM = 2'd2, BS_ZERO = 2'd3;
  localparam logic [1:0] WS_REG = 2'd0, WS_MEM = 2'd1, WS_PC = 2'd2, WS_IMM = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_TWO = 2'd2;

  localparam logic [3:0] A_ADD = 4'd0, A_ORR = 4'd3, A_SHR = 4'd7;
  localparam logic [3:0] A_NEQ = 4'd8, A_EQ = 4'd9, A_GTZ = 4'd10, A_LTZ = 4'd11;

  localparam logic [3:0] O_BNE = 4'd0, O_BEQ = 4'd1, O_BGZ = 4'd2, O_BLZ = 4'd3;
  localparam logic [3:0] O_ADI = 4'd4, O_ORI = 4'd5, O_LHI = 4'd6, O_LWD = 4'd7;
  localparam logic [3:0] O_SWD = 4'd8, O_JAL = 4'd10, O_RT = 4'd15;
  localparam logic [5:0] F_ADD = 6'd0, F_SHR = 6'd7, F_UND = 6'd12, F_JPR = 6'd25;
  localparam logic [5:0] F_JRL = 6'd26, F_WWD = 6'd28, F_HLT = 6'd29;

  typedef struct {
    logic        rst_n;
    logic [3:0]  opc;
    logic [5:0]  fn;
    logic        rdy;
    logic [11:0] strb;
    logic [7:0]  sel;
    logic [3:0]  alu;
    logic [15:0] num;
    logic        halt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] sl(logic [1:0] pcs, logic [1:0] sb, logic [1:0] ws, logic [1:0] rd);
    return {pcs, sb, ws, rd};
  endfunction

  function automatic vec_t mk(logic r, logic [3:0] o, logic [5:0] f, logic y, logic [11:0] s,
                              logic [7:0] se, logic [3:0] a, logic [15:0] n, logic h);
    vec_t v;
    v.rst_n = r; v.opc = o; v.fn = f; v.rdy = y; v.strb = s;
    v.sel = se; v.alu = a; v.num = n; v.halt = h;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare at the falling edge, then cross the rising edge
  task automatic apply(vec_t v, int idx);
    logic [11:0] strb;
    reset_n = v.rst_n; opcode = v.opc; func_code = v.fn; input_ready = v.rdy;
    @(negedge clk);
    strb = {pc_write, pc_write_cond, i_or_d, ir_write, alu_src_a, alu_src_swap,
            reg_write, output_write, i_mem_read, i_mem_write, d_mem_read, d_mem_write};
    chk("strobes", idx, 32'(strb), 32'(v.strb));
    chk("selects", idx, 32'({pc_src, alu_src_b, reg_write_src, reg_dst}), 32'(v.sel));
    chk("alu_op", idx, 32'(alu_op), 32'(v.alu));
    chk("num_inst", idx, 32'(num_inst), 32'(v.num));
    chk("is_halted", idx, 32'(is_halted), 32'(v.halt));
    chk("mem_req_onehot", idx, 32'($countones(strb[3:0]) <= 1), 32'd1);
    $display("step %0d: rst_n=%0d opc=%0d fn=%0d rdy=%0d strb=%03h num=%0d halt=%0d",
             idx, v.rst_n, v.opc, v.fn, v.rdy, strb, num_inst, is_halted);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ifs, ids;
    ifs = sl(PS_SEQ, BS_ONE, WS_REG, RD_RT);
    ids = sl(PS_SEQ, BS_IMM, WS_REG, RD_RT);

    reset_n = 1'b0; opcode = 4'd0; func_code = 6'd0; input_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset, then ADD $3,$1,$2 with memory ready on the first fetch cycle
    vecs.push_back(mk(0, O_RT, F_ADD, 1, NONE, 8'h00, A_ADD, 0, 0));
    vecs.push_back(mk(1, O_RT, F_ADD, 1, IMR|IRW|PCW, ifs, A_ADD, 0, 0));
    vecs.push_back(mk(1, O_RT, F_ADD, 0, NONE, ids, A_ADD, 0, 0));
    vecs.push_back(mk(1, O_RT, F_ADD, 0, SA, sl(PS_SEQ, BS_REG, WS_REG, RD_RT), A_ADD, 0, 0));
    vecs.push_back(mk(1, O_RT, F_ADD, 0, RW, sl(PS_SEQ, BS_REG, WS_REG, RD_RD), A_ADD, 0, 0));
    // LWD: one fetch wait, then MEM stalled 3 cycles
    vecs.push_back(mk(1, O_LWD, 0, 0, IMR, ifs, A_ADD, 1, 0));
    vecs.push_back(mk(1, O_LWD, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 1, 0));
    vecs.push_back(mk(1, O_LWD, 0, 0, NONE, ids, A_ADD, 1, 0));
    vecs.push_back(mk(1, O_LWD, 0, 0, SA, sl(PS_SEQ, BS_IMM, WS_REG, RD_RT), A_ADD, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, O_LWD, 0, 0, IOD|DMR, 8'h00, A_ADD, 1, 0));
    vecs.push_back(mk(1, O_LWD, 0, 1, IOD|DMR, 8'h00, A_ADD, 1, 0));
    vecs.push_back(mk(1, O_LWD, 0, 0, RW, sl(PS_SEQ, BS_REG, WS_MEM, RD_RT), A_ADD, 1, 0));
    // BEQ
    vecs.push_back(mk(1, O_BEQ, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 2, 0));
    vecs.push_back(mk(1, O_BEQ, 0, 0, NONE, ids, A_ADD, 2, 0));
    vecs.push_back(mk(1, O_BEQ, 0, 0, PWC|SA, sl(PS_BR, BS_REG, WS_REG, RD_RT), A_EQ, 2, 0));
    // JAL
    vecs.push_back(mk(1, O_JAL, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 3, 0));
    vecs.push_back(mk(1, O_JAL, 0, 0, PCW|RW, sl(PS_JUMP, BS_IMM, WS_PC, RD_TWO), A_ADD, 3, 0));
    // ADI, ORI
    vecs.push_back(mk(1, O_ADI, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 4, 0));
    vecs.push_back(mk(1, O_ADI, 0, 0, NONE, ids, A_ADD, 4, 0));
    vecs.push_back(mk(1, O_ADI, 0, 0, SA, sl(PS_SEQ, BS_IMM, WS_REG, RD_RT), A_ADD, 4, 0));
    vecs.push_back(mk(1, O_ADI, 0, 0, RW, sl(PS_SEQ, BS_REG, WS_REG, RD_RT), A_ADD, 4, 0));
    vecs.push_back(mk(1, O_ORI, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 5, 0));
    vecs.push_back(mk(1, O_ORI, 0, 0, NONE, ids, A_ADD, 5, 0));
    vecs.push_back(mk(1, O_ORI, 0, 0, SA, sl(PS_SEQ, BS_IMM, WS_REG, RD_RT), A_ORR, 5, 0));
    vecs.push_back(mk(1, O_ORI, 0, 0, RW, sl(PS_SEQ, BS_REG, WS_REG, RD_RT), A_ADD, 5, 0));
    // SWD with one MEM stall
    vecs.push_back(mk(1, O_SWD, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 6, 0));
    vecs.push_back(mk(1, O_SWD, 0, 0, NONE, ids, A_ADD, 6, 0));
    vecs.push_back(mk(1, O_SWD, 0, 0, SA, sl(PS_SEQ, BS_IMM, WS_REG, RD_RT), A_ADD, 6, 0));
    vecs.push_back(mk(1, O_SWD, 0, 0, IOD|DMW, 8'h00, A_ADD, 6, 0));
    vecs.push_back(mk(1, O_SWD, 0, 1, IOD|DMW, 8'h00, A_ADD, 6, 0));
    // BGZ
    vecs.push_back(mk(1, O_BGZ, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 7, 0));
    vecs.push_back(mk(1, O_BGZ, 0, 0, NONE, ids, A_ADD, 7, 0));
    vecs.push_back(mk(1, O_BGZ, 0, 0, PWC|SA, sl(PS_BR, BS_ZERO, WS_REG, RD_RT), A_GTZ, 7, 0));
    // SHR
    vecs.push_back(mk(1, O_RT, F_SHR, 1, IMR|IRW|PCW, ifs, A_ADD, 8, 0));
    vecs.push_back(mk(1, O_RT, F_SHR, 0, NONE, ids, A_ADD, 8, 0));
    vecs.push_back(mk(1, O_RT, F_SHR, 0, SA, 8'h00, A_SHR, 8, 0));
    vecs.push_back(mk(1, O_RT, F_SHR, 0, RW, sl(PS_SEQ, BS_REG, WS_REG, RD_RD), A_ADD, 8, 0));
    // LHI, JPR, WWD, undefined func, JRL: all finish in ID
    vecs.push_back(mk(1, O_LHI, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 9, 0));
    vecs.push_back(mk(1, O_LHI, 0, 0, RW, sl(PS_SEQ, BS_IMM, WS_IMM, RD_RT), A_ADD, 9, 0));
    vecs.push_back(mk(1, O_RT, F_JPR, 1, IMR|IRW|PCW, ifs, A_ADD, 10, 0));
    vecs.push_back(mk(1, O_RT, F_JPR, 0, PCW, sl(PS_REG, BS_IMM, WS_REG, RD_RT), A_ADD, 10, 0));
    vecs.push_back(mk(1, O_RT, F_WWD, 1, IMR|IRW|PCW, ifs, A_ADD, 11, 0));
    vecs.push_back(mk(1, O_RT, F_WWD, 0, OW, ids, A_ADD, 11, 0));
    vecs.push_back(mk(1, O_RT, F_UND, 1, IMR|IRW|PCW, ifs, A_ADD, 12, 0));
    vecs.push_back(mk(1, O_RT, F_UND, 0, NONE, ids, A_ADD, 12, 0));
    vecs.push_back(mk(1, O_RT, F_JRL, 1, IMR|IRW|PCW, ifs, A_ADD, 13, 0));
    vecs.push_back(mk(1, O_RT, F_JRL, 0, PCW|RW, sl(PS_REG, BS_IMM, WS_PC, RD_TWO), A_ADD, 13, 0));
    // BNE, BLZ
    vecs.push_back(mk(1, O_BNE, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 14, 0));
    vecs.push_back(mk(1, O_BNE, 0, 0, NONE, ids, A_ADD, 14, 0));
    vecs.push_back(mk(1, O_BNE, 0, 0, PWC|SA, sl(PS_BR, BS_REG, WS_REG, RD_RT), A_NEQ, 14, 0));
    vecs.push_back(mk(1, O_BLZ, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 15, 0));
    vecs.push_back(mk(1, O_BLZ, 0, 0, NONE, ids, A_ADD, 15, 0));
    vecs.push_back(mk(1, O_BLZ, 0, 0, PWC|SA, sl(PS_BR, BS_ZERO, WS_REG, RD_RT), A_LTZ, 15, 0));
    // HLT, then ready pulses are ignored; reset recovers
    vecs.push_back(mk(1, O_RT, F_HLT, 1, IMR|IRW|PCW, ifs, A_ADD, 16, 0));
    vecs.push_back(mk(1, O_RT, F_HLT, 0, NONE, ids, A_ADD, 16, 0));
    vecs.push_back(mk(1, O_RT, F_HLT, 1, NONE, 8'h00, A_ADD, 17, 1));
    vecs.push_back(mk(1, O_RT, F_HLT, 1, NONE, 8'h00, A_ADD, 17, 1));
    vecs.push_back(mk(0, O_RT, F_HLT, 1, NONE, 8'h00, A_ADD, 17, 0));
    vecs.push_back(mk(1, O_RT, F_HLT, 0, IMR, ifs, A_ADD, 0, 0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // Reset while SWD is waiting in MEM: no write strobe once reset is seen
    apply(mk(1, O_SWD, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 0, 0), 100);
    apply(mk(1, O_SWD, 0, 0, NONE, ids, A_ADD, 0, 0), 101);
    apply(mk(1, O_SWD, 0, 0, SA, sl(PS_SEQ, BS_IMM, WS_REG, RD_RT), A_ADD, 0, 0), 102);
    apply(mk(1, O_SWD, 0, 0, IOD|DMW, 8'h00, A_ADD, 0, 0), 103);
    apply(mk(0, O_SWD, 0, 1, NONE, 8'h00, A_ADD, 0, 0), 104);
    apply(mk(1, O_SWD, 0, 0, IMR, ifs, A_ADD, 0, 0), 105);

`ifdef CTRL_MEM_TIMEOUT_EN
    // Fetch stall with limit 4: IF has already waited once (step 105)
    for (int i = 0; i < 3; i++)
      apply(mk(1, O_ADI, 0, 0, IMR, ifs, A_ADD, 0, 0), 200 + i);
    apply(mk(1, O_ADI, 0, 1, NONE, 8'h00, A_ADD, 0, 1), 203);
`else
    // Without the watchdog a fetch stall is unbounded
    for (int i = 0; i < 20; i++)
      apply(mk(1, O_ADI, 0, 0, IMR, ifs, A_ADD, 0, 0), 200 + i);
    apply(mk(1, O_ADI, 0, 1, IMR|IRW|PCW, ifs, A_ADD, 0, 0), 220);
    apply(mk(1, O_ADI, 0, 0, NONE, ids, A_ADD, 0, 0), 221);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore FSM that sequences the 16-bit multicycle TSC datapath through fetch/decode/execute/memory/writeback.
- Consumes decoded opcode/func_code and the memory input_ready handshake.
- Drives every datapath control strobe, memory read/write requests, retired-instruction counter and halt flag.
- Sits beside the datapath inside the CPU top; memory sits outside it.

Parameters:
WORD_SIZE, 16, width of num_inst
MEM_TIMEOUT, 15, max cycles waiting on input_ready before fault (only with CTRL_MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
opcode  in  4  IR[15:12]
func_code  in  6  IR[5:0]
input_ready  in  1  memory completed current read/write this cycle
pc_write, pc_write_cond, i_or_d, ir_write, alu_src_a, alu_src_swap, reg_write, output_write  out  1 each  datapath strobes
pc_src, alu_src_b, reg_write_src, reg_dst  out  2 each  datapath selects
alu_op  out  4  ALU operation
i_mem_read, i_mem_write, d_mem_read, d_mem_write  out  1 each  memory requests
num_inst  out  WORD_SIZE  retired instruction count
is_halted  out  1  HLT executed (or fault)

Behaviour:
- Reset (reset_n=0 at posedge): state=IF, num_inst=0, is_halted=0. All strobes are Moore outputs and therefore 0 during reset; alu_op=ALU_ADD; selects=0.
- States: IF, ID, EX, MEM, WB, HALT.
- IF: i_mem_read=1, alu_src_a=PC, alu_src_b=ONE, alu_op=ADD.
  - input_ready=0: hold IF.
  - input_ready=1: ir_write=1, pc_write=1, pc_src=SEQ, next state ID.
- ID: alu_out<=PC+sext(imm) (branch target).
  - JMP: pc_write, pc_src=JUMP; retire; next IF.
  - JAL: additionally reg_write, reg_dst=2, reg_write_src=PC; retire; next IF.
  - LHI: reg_write, reg_dst=RT, reg_write_src=IMM; retire; next IF.
  - JPR: pc_write, pc_src=REG; retire; next IF.
  - JRL: JPR plus $2<=PC; retire; next IF.
  - WWD: output_write=1; retire; next IF.
  - HLT: retire; next HALT.
  - Undefined opcode/func: retire as NOP; next IF.
  - Otherwise: next EX.
- EX:
  - R-type arithmetic (ADD,SUB,AND,ORR,NOT,TCP,SHL,SHR): alu_src_a=REG, alu_src_b=REG, alu_op=func; next WB.
  - ADI/ORI: alu_src_b=IMM; next WB.
  - LWD/SWD: alu_src_b=IMM, alu_op=ADD; next MEM.
  - BNE/BEQ: alu_src_b=REG, alu_op=NEQ/EQ.
  - BGZ/BLZ: alu_src_b=ZERO, alu_op=GTZ/LTZ.
  - All branches: pc_write_cond=1, pc_src=BRANCH; retire; next IF. Taken iff ALU result nonzero.
- MEM: i_or_d=1; d_mem_read (LWD) or d_mem_write (SWD) held until input_ready=1.
  - SWD: retire on input_ready; next IF.
  - LWD: next WB.
- WB: reg_write=1.
  - R-type: reg_dst=RD, src=REG.
  - ADI/ORI: reg_dst=RT, src=REG.
  - LWD: reg_dst=RT, src=MEM.
  - Retire; next IF.
- Retire: num_inst increments by 1 on the posedge leaving the instruction's final state; wraps 0xFFFF->0x0000.
- HALT: absorbing; all strobes 0, is_halted=1; only reset exits.
- Reset mid-wait (IF/MEM): returns to IF, no write strobe issued after the reset edge.
- Memory requests never overlap: at most one of the four *_mem_* outputs is 1 in any cycle.

Optional Feature:
CTRL_MEM_TIMEOUT_EN
- Defined: 4-bit wait counter, cleared on entering IF or MEM and incremented each cycle input_ready=0. When the count reaches MEM_TIMEOUT, FSM enters HALT with is_halted=1; num_inst is not incremented.
- Undefined: no counter; wait is unbounded.

Decomposition:
- Shared constants header (existing constants.v) holds ALUSRCA_*, ALUSRCB_*, PCSRC_*, REGDST_*, REGWRITESRC_*.
- New entries in the same header:
  - OPC_* opcodes: BNE 0, BEQ 1, BGZ 2, BLZ 3, ADI 4, ORI 5, LHI 6, LWD 7, SWD 8, JMP 9, JAL 10, RTYPE 15.
  - FUNC_* codes: ADD 0 … SHR 7, JPR 25, JRL 26, WWD 28, HLT 29.
  - ALU_* ops including NEQ/EQ/GTZ/LTZ.
  - STATE_* encodings.
- One natural sub-module: control_decode, combinational (opcode, func_code) -> instruction class and alu_op; the FSM instantiates it.

Test Plan:
- ADD $3,$1,$2, input_ready=1 on first IF cycle -> states IF,ID,EX,WB; reg_write=1 with reg_dst=RD in cycle 4; num_inst 0->1.
- LWD with input_ready delayed 3 cycles in MEM -> d_mem_read high 4 cycles; WB src=MEM next cycle; 5+3 cycles total.
- BEQ, equal registers -> EX shows pc_write_cond=1, pc_src=BRANCH, alu_op=EQ; instruction retires after 3 cycles.
- JAL 0x123 -> in ID: pc_write=1, pc_src=JUMP, reg_write=1, reg_dst=2, src=PC in same cycle.
- HLT then input_ready pulses -> is_halted=1, no further i_mem_read; reset_n=0 -> IF, num_inst=0.
- With CTRL_MEM_TIMEOUT_EN, MEM_TIMEOUT=4, input_ready stuck 0 in IF -> HALT after 4 wait cycles, num_inst unchanged.
